// File: rtl/hue_stage2_pkg.sv
// hue_stage2_pkg: shared constants for the hue pipeline final stage.
//   - function codes (which channel held the maximum)
//   - per-code hue offsets in degrees
//   - hue range and width
package hue_stage2_pkg;

  localparam int HUE_W   = 9;
  localparam int HUE_MAX = 360;
  localparam int CODE_W  = 2;

  typedef enum logic [CODE_W-1:0] {
    FN_NONE  = 2'd0,
    FN_RED   = 2'd1,
    FN_GREEN = 2'd2,
    FN_BLUE  = 2'd3
  } func_e;

  localparam logic [HUE_W-1:0] OFF_RED   = 9'd0;
  localparam logic [HUE_W-1:0] OFF_GREEN = 9'd120;
  localparam logic [HUE_W-1:0] OFF_BLUE  = 9'd240;

  // Code 0 is never produced upstream; it falls back to the red offset.
  function automatic logic [HUE_W-1:0] hue_offset(input logic [CODE_W-1:0] code);
    logic [HUE_W-1:0] off;
    off = OFF_RED;
    case (func_e'(code))
      FN_GREEN: off = OFF_GREEN;
      FN_BLUE:  off = OFF_BLUE;
      default:  off = OFF_RED;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/hue_code_fifo.sv
// hue_code_fifo: in-order synchronous FIFO for per-pixel function codes.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata   write request and data; refused when full unless popping
//   pop, rdata    read request; rdata is the head entry (first-word fall-through)
//   full, empty   occupancy flags
module hue_code_fifo
  import hue_stage2_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = CODE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hue_stage2.sv
// hue_stage2: final hue pipeline stage. Pairs each divider ratio with the
// function code queued ahead of it and converts to hue degrees 0..359.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_func_valid   push i_function into the code FIFO
//   i_function     function code 1=red max, 2=green max, 3=blue max
//   i_div_valid    divider result valid; pops one code
//   i_ratio        signed ratio: sign, 1 integer bit, FRAC_W fraction bits
//   i_err_clr      clears o_err
//   o_hue          hue in degrees, held when o_valid is low
//   o_valid        single-cycle pulse per result, 2 cycles after i_div_valid
//   o_err          sticky FIFO overflow/underflow flag
// Build option: define HUE_ROUND_EN for round-half-up degrees; otherwise floor.
module hue_stage2
  import hue_stage2_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAC_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_func_valid,
  input  logic [1:0]        i_function,
  input  logic              i_div_valid,
  input  logic [FRAC_W+1:0] i_ratio,
  input  logic              i_err_clr,
  output logic [8:0]        o_hue,
  output logic              o_valid,
  output logic              o_err
);

  localparam int RW  = FRAC_W + 2;
  localparam int PW  = FRAC_W + 9;
  localparam int HCW = HUE_W + 3;
  localparam int HALF = 1 << (FRAC_W - 1);

  localparam logic signed [RW-1:0] SAT_POS = RW'(1 << FRAC_W);
  localparam logic signed [RW-1:0] SAT_NEG = RW'(-(1 << FRAC_W));

  logic [CODE_W-1:0] fifo_code;
  logic              fifo_full;
  logic              fifo_empty;
  logic              err_new;

  logic signed [RW-1:0] ratio_s;
  logic signed [RW-1:0] ratio_sat;

  logic                 a_valid;
  logic [CODE_W-1:0]    a_code;
  logic signed [RW-1:0] a_ratio;

  logic signed [PW-1:0]  r_ext;
  logic signed [PW-1:0]  p;
  logic signed [PW-1:0]  p_rnd;
  logic signed [PW-1:0]  d;
  logic signed [HCW-1:0] h_sum;
  logic signed [HCW-1:0] h_wrap;

  hue_code_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(CODE_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_func_valid),
    .pop   (i_div_valid),
    .wdata (i_function),
    .rdata (fifo_code),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Underflow counts even if a push lands in the same cycle; overflow only
  // when no pop frees a slot.
  assign err_new = (i_div_valid & fifo_empty) |
                   (i_func_valid & fifo_full & ~i_div_valid);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (err_new) begin
      o_err <= 1'b1;
    end else if (i_err_clr) begin
      o_err <= 1'b0;
    end
  end

  // Saturation bounds divide-by-zero garbage from gray pixels to +/-1.0.
  always_comb begin
    ratio_s   = signed'(i_ratio);
    ratio_sat = ratio_s;
    if (ratio_s > SAT_POS)      ratio_sat = SAT_POS;
    else if (ratio_s < SAT_NEG) ratio_sat = SAT_NEG;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_valid <= 1'b0;
      a_code  <= '0;
      a_ratio <= '0;
    end else begin
      a_valid <= i_div_valid & ~fifo_empty;
      if (i_div_valid & ~fifo_empty) begin
        a_code  <= fifo_code;
        a_ratio <= ratio_sat;
      end
    end
  end

  always_comb begin
    r_ext = PW'(a_ratio);
    p     = (r_ext <<< 6) - (r_ext <<< 2);
`ifdef HUE_ROUND_EN
    p_rnd = p + PW'(HALF);
`else
    p_rnd = p;
`endif
    d      = p_rnd >>> FRAC_W;
    h_sum  = HCW'(d) + $signed({3'b000, hue_offset(a_code)});
    h_wrap = h_sum;
    if (h_sum < 0)             h_wrap = h_sum + HCW'(HUE_MAX);
    else if (h_sum >= HUE_MAX) h_wrap = h_sum - HCW'(HUE_MAX);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_hue   <= '0;
    end else begin
      o_valid <= a_valid;
      if (a_valid) o_hue <= h_wrap[HUE_W-1:0];
    end
  end

endmodule

// File: tb/tb_hue_stage2.sv
// tb_hue_stage2: directed and randomized checks of hue_stage2 against a
// queue-based reference model computing hue with plain integer arithmetic.
module tb_hue_stage2;

  localparam int DEPTH = 16;
  localparam int FW    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fv = 1'b0;
  logic [1:0] fn = '0;
  logic       dv = 1'b0;
  logic [9:0] ratio = '0;
  logic       clr = 1'b0;
  logic [8:0] hue;
  logic       valid;
  logic       err;

  always #5 clk = ~clk;

  hue_stage2 #(
    .FIFO_DEPTH(DEPTH),
    .FRAC_W(FW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_func_valid (fv),
    .i_function   (fn),
    .i_div_valid  (dv),
    .i_ratio      (ratio),
    .i_err_clr    (clr),
    .o_hue        (hue),
    .o_valid      (valid),
    .o_err        (err)
  );

  typedef struct {
    int due;
    int hue;
  } pend_t;

  int    checks = 0;
  int    errors = 0;
  int    q[$];
  pend_t pend[$];
  int    ecount = 0;
  int    m_hue = 0;
  bit    m_err = 1'b0;
  int    valid_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int qq;
    qq = a / b;
    if ((a % b != 0) && (a < 0)) qq = qq - 1;
    return qq;
  endfunction

  function automatic int ref_hue(input int code, input int r);
    int rc;
    int num;
    int deg;
    int off;
    rc = (r > 256) ? 256 : ((r < -256) ? -256 : r);
    num = 60 * rc;
`ifdef HUE_ROUND_EN
    num = num + 128;
`endif
    deg = fdiv(num, 256);
    off = (code == 2) ? 120 : ((code == 3) ? 240 : 0);
    return (((deg + off) % 360) + 360) % 360;
  endfunction

  // One clock: drive inputs, advance the model by the queue rules, check outputs.
  task automatic step(input bit f, input int code, input bit d, input int r, input bit c);
    bit    m_valid;
    bit    ev;
    int    popped;
    pend_t e;
    fv = f; fn = 2'(code); dv = d; ratio = 10'(r); clr = c;
    @(posedge clk);
    ecount++;
    ev = 1'b0;
    if (d) begin
      if (q.size() == 0) ev = 1'b1;
      else begin
        popped = q.pop_front();
        e.due = ecount + 1;
        e.hue = ref_hue(popped, r);
        pend.push_back(e);
      end
    end
    if (f) begin
      if (q.size() < DEPTH) q.push_back(code);
      else ev = 1'b1;
    end
    if (ev) m_err = 1'b1;
    else if (c) m_err = 1'b0;
    m_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == ecount) begin
      m_valid = 1'b1;
      m_hue = pend[0].hue;
      pend.delete(0);
    end
    #1;
    chk("o_valid", valid, m_valid);
    chk("o_hue", hue, m_hue);
    chk("o_err", err, m_err);
    if (valid) valid_seen++;
    fv = 1'b0; dv = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    fv = 1'b0; dv = 1'b0; clr = 1'b0;
    rst = 1'b1;
    #1;
    q.delete();
    pend.delete();
    m_hue = 0;
    m_err = 1'b0;
    chk("rst_valid", valid, 0);
    chk("rst_hue", hue, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic conv(input string tag, input int code, input int r, input int exp_hue);
    step(1'b1, code, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1, r, 1'b0);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    chk(tag, hue, exp_hue);
    chk({tag, "_valid"}, valid, 1);
    step(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    do_reset();

    conv("basic_30", 1, 128, 30);
    conv("basic_330", 1, -128, 330);
    conv("green_p256", 2, 256, 180);
    conv("blue_m256", 3, -256, 180);
    conv("blue_p256", 3, 256, 300);
    conv("green_m256", 2, -256, 60);
    conv("sat_pos", 2, 511, 180);
    chk("sat_no_err", err, 0);
    conv("sat_neg", 1, -512, 300);
`ifdef HUE_ROUND_EN
    conv("round_3", 1, 3, 1);
    conv("round_m1", 1, -1, 0);
`else
    conv("floor_3", 1, 3, 0);
    conv("floor_m1", 1, -1, 359);
`endif

    // Overflow, drain in order, underflow on the 17th pop, then clear.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, int'($urandom_range(1, 3)), 1'b0, 0, 1'b0);
    chk("full_no_err", err, 0);
    step(1'b1, 1, 1'b0, 0, 1'b0);
    chk("overflow_err", err, 1);
    valid_seen = 0;
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 0, 1'b1, int'($urandom_range(0, 1023)) - 512, 1'b0);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    chk("drain_results", valid_seen, DEPTH);
    step(1'b0, 0, 1'b0, 0, 1'b1);
    chk("err_clear", err, 0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) step(1'b1, int'($urandom_range(1, 3)), 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b1, int'($urandom_range(1, 3)), 1'b1, int'($urandom_range(0, 1023)) - 512, 1'b0);
    chk("full_pushpop_no_err", err, 0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 1'b1, int'($urandom_range(0, 1023)) - 512, 1'b0);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    chk("full_pushpop_end_err", err, 0);

    // Reset with a result in flight.
    step(1'b1, 2, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1, 100, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1, 50, 1'b0);
    chk("post_reset_underflow", err, 1);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    chk("post_reset_no_valid", valid, 0);
    step(1'b0, 0, 1'b0, 0, 1'b1);

    // Randomized traffic, occasional underflow/overflow and clears.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit f;
      bit d;
      bit c;
      f = ($urandom_range(0, 1) == 1);
      d = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 19) == 0);
      step(f, int'($urandom_range(1, 3)), d, int'($urandom_range(0, 1023)) - 512, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
